// File: rtl/axi3_slave_mem.sv
// AXI3 slave endpoint backed by a word-organised on-chip memory; FIXED/INCR/WRAP bursts, SLVERR on bad requests.
// Latency: write response one cycle after the last W beat; read data one cycle after the AR handshake, then one beat per R handshake.
// Backpressure: BVALID and RVALID/RDATA/RID/RRESP/RLAST hold until BREADY/RREADY; AW/AR are accepted only while their engine is idle.
// Optional macro AXI_MEM_WLAST_CHK_EN: flags a misplaced WLAST as SLVERR (the beat count still ends the burst).
module axi3_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LG     = $clog2(STRB_W);
  localparam int IW     = $clog2(MEM_DEPTH);
  // Wide enough that start + 16 beats of up to 128 bytes never overflows.
  localparam int EW     = ADDR_WIDTH + 12;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Whole-burst error check done once at request time, so no beat of a bad burst ever touches memory.
  function automatic logic req_err(input logic [ADDR_WIDTH-1:0] a, input logic [3:0] len,
                                   input logic [2:0] sz, input logic [1:0] bt);
    logic [EW-1:0] bytes, span, last;
    bytes = EW'(1) << sz;
    span  = bytes * (EW'(len) + EW'(1));
    case (bt)
      2'd1:    last = (EW'(a) & ~(bytes - EW'(1))) + bytes * EW'(len);
      2'd2:    last = (EW'(a) & ~(span - EW'(1))) + span - EW'(1);
      default: last = EW'(a);
    endcase
    req_err = (sz > 3'(LG)) || (bt == 2'd3) ||
              ((bt == 2'd2) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
              ((last >> LG) >= EW'(MEM_DEPTH));
  endfunction

  // Address of the beat following address a.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [3:0] len,
                                                       input logic [2:0] sz, input logic [1:0] bt);
    logic [ADDR_WIDTH-1:0] bytes, aligned, mask;
    bytes   = ADDR_WIDTH'(1) << sz;
    aligned = a & ~(bytes - ADDR_WIDTH'(1));
    mask    = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) - ADDR_WIDTH'(1);
    case (bt)
      2'd1:    next_addr = aligned + bytes;
      2'd2:    next_addr = (a & ~mask) | ((aligned + bytes) & mask);
      default: next_addr = a;
    endcase
  endfunction

  // ---------------- write engine ----------------
  wstate_t               wstate_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   awid_q, bid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [3:0]            awlen_q, wcnt_q;
  logic [2:0]            awsize_q;
  logic [1:0]            awburst_q, bresp_q;
  logic                  werr_q, wlast_err_q;
  logic                  aw_err, w_hs, wlast_bad;
  logic [IW-1:0]         w_idx;

  assign aw_err = req_err(AWADDR, AWLEN, AWSIZE, AWBURST);
  assign w_hs   = WVALID && wready_q;
  assign w_idx  = awaddr_q[LG +: IW];

`ifdef AXI_MEM_WLAST_CHK_EN
  assign wlast_bad = w_hs && (WLAST != (wcnt_q == awlen_q));
`else
  assign wlast_bad = 1'b0;
`endif

  // Write FSM: accept AW, count W beats, then hold the B response until taken.
  always_ff @(posedge clk) begin
    if (resetn) begin
      wstate_q    <= W_IDLE;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      awid_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= 4'd0;
      awsize_q    <= 3'd0;
      awburst_q   <= 2'd0;
      wcnt_q      <= 4'd0;
      werr_q      <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: if (AWVALID) begin
          awid_q      <= AWID;
          awaddr_q    <= AWADDR;
          awlen_q     <= AWLEN;
          awsize_q    <= AWSIZE;
          awburst_q   <= AWBURST;
          werr_q      <= aw_err;
          wlast_err_q <= 1'b0;
          wcnt_q      <= 4'd0;
          awready_q   <= 1'b0;
          wready_q    <= 1'b1;
          wstate_q    <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          awaddr_q <= next_addr(awaddr_q, awlen_q, awsize_q, awburst_q);
          wcnt_q   <= wcnt_q + 4'd1;
          if (wlast_bad) wlast_err_q <= 1'b1;
          if (wcnt_q == awlen_q) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bid_q    <= awid_q;
            bresp_q  <= (werr_q || wlast_err_q || wlast_bad) ? 2'b10 : 2'b00;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: if (BREADY) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write; suppressed for errored bursts and while reset aborts a burst.
  always_ff @(posedge clk) begin
    if (!resetn && w_hs && !werr_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_t               rstate_q;
  logic                  arready_q, rvalid_q, rlast_q, rerr_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] araddr_q, r_next;
  logic [3:0]            arlen_q, rcnt_q;
  logic [2:0]            arsize_q;
  logic [1:0]            arburst_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ar_err;

  assign ar_err = req_err(ARADDR, ARLEN, ARSIZE, ARBURST);
  assign r_next = next_addr(araddr_q, arlen_q, arsize_q, arburst_q);

  // Read FSM: registered memory read for beat 0 on AR, then next beat fetched on each R handshake.
  always_ff @(posedge clk) begin
    if (resetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rerr_q    <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      araddr_q  <= '0;
      arlen_q   <= 4'd0;
      arsize_q  <= 3'd0;
      arburst_q <= 2'd0;
      rcnt_q    <= 4'd0;
    end else begin
      case (rstate_q)
        R_IDLE: if (ARVALID) begin
          araddr_q  <= ARADDR;
          arlen_q   <= ARLEN;
          arsize_q  <= ARSIZE;
          arburst_q <= ARBURST;
          rerr_q    <= ar_err;
          rid_q     <= ARID;
          rresp_q   <= ar_err ? 2'b10 : 2'b00;
          rdata_q   <= ar_err ? '0 : mem[ARADDR[LG +: IW]];
          rlast_q   <= (ARLEN == 4'd0);
          rcnt_q    <= 4'd0;
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          rstate_q  <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end else begin
            araddr_q <= r_next;
            rcnt_q   <= rcnt_q + 4'd1;
            rdata_q  <= rerr_q ? '0 : mem[r_next[LG +: IW]];
            rlast_q  <= ((rcnt_q + 4'd1) == arlen_q);
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{WID, WLAST};

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi3_slave_mem.sv
// Bench for axi3_slave_mem: table of burst/response vectors, directed corner sequences, random bursts vs a memory model.
module tb_axi3_slave_mem;
  localparam int DW = 32, AW = 32, IDW = 4, DEPTH = 1024;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic           AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [IDW-1:0] AWID, WID, BID, ARID, RID;
  logic [AW-1:0]  AWADDR, ARADDR;
  logic [3:0]     AWLEN, ARLEN;
  logic [2:0]     AWSIZE, ARSIZE;
  logic [1:0]     AWBURST, ARBURST, BRESP, RRESP;
  logic [DW-1:0]  WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic           ARVALID, ARREADY, RVALID, RREADY, RLAST;

  axi3_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [DEPTH];      // reference memory contents
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [31:0] rcap [16];
  logic [1:0]  rrcap [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Byte address of beat i, straight from the burst rules.
  function automatic longint beat_addr(input longint start, input int len, input int size, input int burst, input int i);
    longint b, tot, al, base;
    b    = longint'(1) << size;
    tot  = b * (len + 1);
    al   = (start / b) * b;
    base = (start / tot) * tot;
    if (i == 0) return start;
    case (burst)
      1:       return al + i * b;
      2:       return base + ((al - base + i * b) % tot);
      default: return start;
    endcase
  endfunction

  function automatic bit mdl_err(input longint start, input int len, input int size, input int burst);
    if (size > 2 || burst == 3) return 1'b1;
    if (burst == 2 && !(len inside {1, 3, 7, 15})) return 1'b1;
    for (int i = 0; i <= len; i++)
      if ((beat_addr(start, len, size, burst, i) >> 2) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  // Full write burst from wdat/wstb; checks BID/BRESP and updates the model.
  task automatic wr_burst(input logic [3:0] id, input longint addr, input int len, input int size,
                          input int burst, input int bdelay, output logic [1:0] resp);
    int n;
    bit e;
    longint a;
    e = mdl_err(addr, len, size, burst);
    AWVALID = 1'b1; AWID = id; AWADDR = 32'(addr); AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("awready");
    @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WVALID = 1'b1; WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == len); WID = id;
      n = 0;
      while (!WREADY && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("wready");
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    n = 0;
    while (!BVALID && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("bvalid");
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk);
      check("bvalid_hold", BVALID, 1);
    end
    resp = BRESP;
    check("bid", BID, id);
    check("bresp", BRESP, e ? 2 : 0);
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 0);
    if (!e)
      for (int i = 0; i <= len; i++) begin
        a = beat_addr(addr, len, size, burst, i);
        for (int j = 0; j < 4; j++)
          if (wstb[i][j]) mdl[int'(a >> 2)][8*j +: 8] = wdat[i][8*j +: 8];
      end
  endtask

  // Full read burst; optionally stalls RREADY on one beat. Captures data/resp into rcap/rrcap.
  task automatic rd_burst(input logic [3:0] id, input longint addr, input int len, input int size,
                          input int burst, input int stall_beat, input int stall_len);
    int n;
    bit e;
    logic [31:0] d, exp_d;
    e = mdl_err(addr, len, size, burst);
    ARVALID = 1'b1; ARID = id; ARADDR = 32'(addr); ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("arready");
    @(negedge clk);
    ARVALID = 1'b0;
    check("r_latency", RVALID, 1);
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!RVALID && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("rvalid");
      d = RDATA;
      if (i == stall_beat) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          check("stall_rvalid", RVALID, 1);
          check("stall_rdata", RDATA, d);
        end
      end
      exp_d = e ? 32'h0 : mdl[int'(beat_addr(addr, len, size, burst, i) >> 2)];
      rcap[i] = RDATA;
      rrcap[i] = RRESP;
      check($sformatf("rdata[%0d]", i), RDATA, exp_d);
      check("rresp", RRESP, e ? 2 : 0);
      check("rlast", RLAST, i == len);
      check("rid", RID, id);
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
    end
    check("rvalid_end", RVALID, 0);
  endtask

  typedef struct {
    longint     addr;
    int         len;
    int         size;
    int         burst;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    int burst, size, len, blen;
    longint addr;

    tbl[0] = '{32'h40,            3,  2, 1, 2'd0};
    tbl[1] = '{32'h44,            7,  2, 2, 2'd0};
    tbl[2] = '{32'h48,            2,  2, 2, 2'd2};
    tbl[3] = '{32'h50,            1,  3, 1, 2'd2};
    tbl[4] = '{32'h60,            0,  2, 3, 2'd2};
    tbl[5] = '{(DEPTH-4)*4,       3,  2, 1, 2'd0};
    tbl[6] = '{(DEPTH-2)*4,       3,  2, 1, 2'd2};
    tbl[7] = '{DEPTH*4,           0,  2, 1, 2'd2};
    tbl[8] = '{(DEPTH-1)*4,       15, 2, 0, 2'd0};
    tbl[9] = '{32'h70,            3,  0, 1, 2'd0};

    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_awready", AWREADY, 1);
    check("rst_arready", ARREADY, 1);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_outs", {BID, BRESP, RID, RDATA, RRESP}, 0);
    resetn = 1'b0;
    @(negedge clk);

    // Preload words 0..127 so every later in-range read has known contents
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      wr_burst(4'(k), k * 64, 15, 2, 1, 0, resp);
    end

    // Basic INCR write/read of 1..4
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    wr_burst(4'h5, 32'h10, 3, 2, 1, 0, resp);
    check("incr_bresp", resp, 0);
    rd_burst(4'h6, 32'h10, 3, 2, 1, -1, 0);
    for (int i = 0; i < 4; i++) check("incr_data", rcap[i], 32'(i + 1));

    // WRAP order 0x38, 0x3C, 0x30, 0x34
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'h30 + 32'(4 * i); wstb[i] = 4'hF; end
    wr_burst(4'h1, 32'h30, 3, 2, 1, 0, resp);
    rd_burst(4'h2, 32'h38, 3, 2, 2, -1, 0);
    check("wrap0", rcap[0], 32'h38);
    check("wrap1", rcap[1], 32'h3C);
    check("wrap2", rcap[2], 32'h30);
    check("wrap3", rcap[3], 32'h34);

    // Backpressure: RREADY low 5 cycles mid-burst, BREADY low 3 cycles
    rd_burst(4'h3, 32'h10, 3, 2, 1, 2, 5);
    check("stall_beat3", rcap[3], 32'h4);
    wdat[0] = 32'hCAFE0001; wstb[0] = 4'hF;
    wr_burst(4'h4, 32'h20, 0, 2, 1, 3, resp);

    // Partial strobe merge
    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    wr_burst(4'h7, 32'h80, 0, 2, 1, 0, resp);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'h3;
    wr_burst(4'h7, 32'h80, 0, 2, 1, 0, resp);
    rd_burst(4'h7, 32'h80, 0, 2, 1, -1, 0);
    check("strobe_merge", rcap[0], 32'h1122CCDD);

    // Vector table: response codes for legal/illegal bursts
    foreach (tbl[t]) begin
      for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      wr_burst(4'(t), tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, 0, resp);
      check($sformatf("tbl%0d_bresp", t), resp, tbl[t].exp);
      rd_burst(4'(t), tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, -1, 0);
      for (int i = 0; i <= tbl[t].len; i++)
        check($sformatf("tbl%0d_rresp", t), rrcap[i], tbl[t].exp);
      if (tbl[t].exp == 2'd2) check($sformatf("tbl%0d_rdata0", t), rcap[0], 0);
    end
    // Errored burst at the top of memory must not have written its in-range beats
    rd_burst(4'h9, (DEPTH-4)*4, 3, 2, 1, -1, 0);

    // Reset during beat 2 of an 8-beat write
    AWVALID = 1'b1; AWID = 4'hA; AWADDR = 32'h100; AWLEN = 4'd7; AWSIZE = 3'd2; AWBURST = 2'd1;
    @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WVALID = 1'b1; WDATA = 32'hBEEF0000 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0;
      @(negedge clk);
      mdl[64 + i] = 32'hBEEF0000 + 32'(i);
    end
    WVALID = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_bvalid", BVALID, 0);
    check("rst_mid_awready", AWREADY, 1);
    check("rst_mid_wready", WREADY, 0);
    rd_burst(4'hB, 32'h100, 7, 2, 1, -1, 0);

    // Random bursts against the model
    for (int it = 0; it < 40; it++) begin
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      if (burst == 2) begin
        blen = $urandom_range(0, 3);
        len = (1 << (blen + 1)) - 1;
      end else len = $urandom_range(0, 15);
      addr = $urandom_range(0, 191);
      if (burst == 2) addr = (addr >> size) << size;
      if ($urandom_range(0, 7) == 0) addr = DEPTH * 4 + $urandom_range(0, 16) * 4;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
        wr_burst(4'($urandom), addr, len, size, burst, $urandom_range(0, 2), resp);
      end else begin
        rd_burst(4'($urandom), addr, len, size, burst, $urandom_range(0, len), $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi3_slave_mem.md
Name: axi3_slave_mem

Overview:
- Parametrised AXI3 slave endpoint backed by a word-organised on-chip memory.
- Implements all five AXI3 channels against the team's AXI3 signal set, with independent read and write engines.
- Generalises the fixed-width AXI3 interface to parametrised data, address and ID widths and memory depth.
- Adds FIXED, INCR and WRAP burst addressing and error responses.
- Sits behind the interconnect as the default test and scratch memory target.

Parameters:
DATA_WIDTH, 32, data bus width in bits; legal values 32, 64, 128.
ADDR_WIDTH, 32, byte-address width.
ID_WIDTH, 4, width of AWID/WID/BID/ARID/RID.
MEM_DEPTH, 1024, number of DATA_WIDTH words.

Ports:
clk  in  1  clock; all logic on its rising edge.
resetn  in  1  reset, synchronous, active-high (asserted = 1 despite the name).
AWVALID  in  1  write-address valid.
AWREADY  out  1  write-address ready.
AWID  in  ID_WIDTH  write transaction ID.
AWADDR  in  ADDR_WIDTH  write start byte address.
AWLEN  in  4  write burst beats minus 1.
AWSIZE  in  3  log2 bytes per beat.
AWBURST  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
WVALID  in  1  write-data valid.
WREADY  out  1  write-data ready.
WID  in  ID_WIDTH  write-data ID; ignored.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte enables.
WLAST  in  1  last write beat.
BVALID  out  1  write-response valid.
BREADY  in  1  write-response ready.
BID  out  ID_WIDTH  write-response ID.
BRESP  out  2  write response: 0 OKAY, 2 SLVERR.
ARVALID  in  1  read-address valid.
ARREADY  out  1  read-address ready.
ARID  in  ID_WIDTH  read transaction ID.
ARADDR  in  ADDR_WIDTH  read start byte address.
ARLEN  in  4  read burst beats minus 1.
ARSIZE  in  3  log2 bytes per beat.
ARBURST  in  2  burst type.
RVALID  out  1  read-data valid.
RREADY  in  1  read-data ready.
RID  out  ID_WIDTH  read-data ID.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response: 0 OKAY, 2 SLVERR.
RLAST  out  1  last read beat.

Behaviour:
- Reset values: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0; BID, BRESP, RID, RDATA, RRESP = 0. Memory contents are not reset.
- Reset mid-burst aborts the burst; both FSMs return to IDLE on the next cycle.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On AW handshake, capture ID/ADDR/LEN/SIZE/BURST, clear the beat counter and error flag, go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write the strobed bytes, advance the address and increment the counter. After beat AWLEN, go to W_RESP.
  - W_RESP: BVALID=1 with BID = captured AWID and BRESP from the error flag. Hold until BREADY, then go to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, capture the request; RVALID rises the next cycle carrying beat 0 (registered read, 1-cycle latency).
  - R_DATA: on an R handshake, present the next beat the following cycle. RLAST=1 on beat ARLEN; its handshake returns the FSM to R_IDLE with RVALID=0.
  - RDATA/RID/RRESP/RLAST are stable while RVALID=1 and RREADY=0.
- Address generation (bytes per beat B = 2^SIZE):
  - FIXED: address constant.
  - INCR: addr+B with unaligned start aligned down after beat 0.
  - WRAP: boundary = B*(LEN+1); addr wraps to the aligned boundary base.
- Memory word index = addr >> log2(DATA_WIDTH/8).
- Error conditions; any one sets SLVERR for the whole burst and suppresses memory writes (reads return 0):
  - word index >= MEM_DEPTH on any beat;
  - SIZE > log2(DATA_WIDTH/8);
  - BURST == 3;
  - WRAP with LEN not in {1,3,7,15}.
- Read and write engines run concurrently. A same-cycle read and write to the same word returns the old data.

Optional Feature:
- Macro AXI_MEM_WLAST_CHK_EN.
- Defined: WLAST=1 before beat AWLEN, or WLAST=0 on beat AWLEN, sets the error flag (BRESP=2). An early WLAST still does not end the burst; the beat count governs.
- Undefined: WLAST is ignored entirely; the beat count alone ends the burst.

Test Plan:
- INCR write AWADDR=0x10, AWLEN=3, AWSIZE=2, WSTRB=0xF, data 1..4 -> BRESP=0, BID=AWID. INCR read of the same range -> RDATA 1,2,3,4, RLAST on beat 3 only.
- WRAP read ARADDR=0x38, ARLEN=3, ARSIZE=2 -> word addresses 0x38, 0x3C, 0x30, 0x34.
- Write AWADDR=MEM_DEPTH*4 -> BRESP=2, memory unchanged. Read at the same address -> RRESP=2 on every beat, RDATA=0.
- RREADY held low for 5 cycles mid-burst -> RVALID stays 1, RDATA stable, no beat lost. BREADY low for 3 cycles -> BVALID held.
- WSTRB=0x3 writing 0xAABBCCDD over 0x11223344 -> readback 0x1122CCDD.
- resetn pulsed during beat 2 of an 8-beat write -> BVALID=0, AWREADY=1 the cycle after reset deasserts.
